// File: rtl/iob_ram_tdp_bist_pkg.sv
// Shared types and pattern helpers for the iob_ram_tdp BIST initiator.
package iob_ram_tdp_bist_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_A = 3'd1,
    RD_B = 3'd2,
    WR_B = 3'd3,
    RD_A = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [1:0] PH_WA_RB = 2'd1;
  localparam logic [1:0] PH_WB_RA = 2'd3;

  // Callers cast the 64-bit result down to DATA_W; the low bits wrap naturally.
  function automatic logic [63:0] pat_word(input logic inv, input logic [63:0] seed,
                                           input logic [63:0] idx);
    logic [63:0] sum;
    sum = seed + idx;
    return inv ? ~sum : sum;
  endfunction

endpackage

// File: rtl/iob_ram_tdp_bist_chk.sv
// One-stage expected-data/address pipeline and comparator for a RAM read port.
module iob_ram_tdp_bist_chk #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [DATA_W-1:0] expected,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dout,
  output logic              mismatch,
  output logic [ADDR_W-1:0] mm_addr
);

  logic              vld_q;
  logic [DATA_W-1:0] exp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      exp_q   <= '0;
      mm_addr <= '0;
    end else begin
      vld_q <= valid;
      if (valid) begin
        exp_q   <= expected;
        mm_addr <= addr;
      end
    end
  end

  // RAM read data lands one cycle after the address was issued, lining up with the pipeline.
  assign mismatch = vld_q && (dout != exp_q);

endmodule

// File: rtl/iob_ram_tdp_bist.sv
// BIST initiator for a true dual-port RAM: write A / read B, then write B / read A.
// Optional IOB_RAM_TDP_BIST_ERRCNT_EN adds err_cnt and runs all phases despite mismatches.
module iob_ram_tdp_bist
  import iob_ram_tdp_bist_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seq_ini,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_phase,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              enA,
  output logic              weA,
  output logic [ADDR_W-1:0] addrA,
  output logic [DATA_W-1:0] dinA,
  input  logic [DATA_W-1:0] doutA,
  output logic              enB,
  output logic              weB,
  output logic [ADDR_W-1:0] addrB,
  output logic [DATA_W-1:0] dinB,
  input  logic [DATA_W-1:0] doutB
`ifdef IOB_RAM_TDP_BIST_ERRCNT_EN
  ,
  output logic [ADDR_W+1:0] err_cnt
`endif
);

  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'((1 << ADDR_W) - 1);
  localparam logic [ADDR_W:0] DRAIN = (ADDR_W+1)'(1 << ADDR_W);
`ifdef IOB_RAM_TDP_BIST_ERRCNT_EN
  localparam bit STOP_ON_FAIL = 1'b0;
`else
  localparam bit STOP_ON_FAIL = 1'b1;
`endif

  state_t            state;
  logic [ADDR_W:0]   i, nxt_i;
  logic [DATA_W-1:0] seed, exp_w, dout_sel, pat_a, pat_b;
  logic              ok, rd_phase, issue, chk_mm, mm, abort;
  logic [ADDR_W-1:0] chk_addr;

  always_comb begin
    rd_phase = (state == RD_B) || (state == RD_A);
    issue    = rd_phase && !i[ADDR_W];
    nxt_i    = i + 1'b1;
    exp_w    = DATA_W'(pat_word(state == RD_A, 64'(seed), 64'(i)));
    pat_a    = DATA_W'(pat_word(1'b0, 64'(seed), 64'(nxt_i)));
    pat_b    = DATA_W'(pat_word(1'b1, 64'(seed), 64'(nxt_i)));
    dout_sel = (state == RD_A) ? doutA : doutB;
    mm       = chk_mm && rd_phase;
    abort    = mm && STOP_ON_FAIL;
  end

  iob_ram_tdp_bist_chk #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (issue),
    .expected (exp_w),
    .addr     (i[ADDR_W-1:0]),
    .dout     (dout_sel),
    .mismatch (chk_mm),
    .mm_addr  (chk_addr)
  );

  // Port outputs are registered: each transition loads what the next cycle drives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      i          <= '0;
      seed       <= '0;
      ok         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_phase <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
      enA        <= 1'b0;
      weA        <= 1'b0;
      addrA      <= '0;
      dinA       <= '0;
      enB        <= 1'b0;
      weB        <= 1'b0;
      addrB      <= '0;
      dinB       <= '0;
`ifdef IOB_RAM_TDP_BIST_ERRCNT_EN
      err_cnt    <= '0;
`endif
    end else begin
      if (mm && ok) begin
        ok         <= 1'b0;
        fail_phase <= (state == RD_B) ? PH_WA_RB : PH_WB_RA;
        fail_addr  <= chk_addr;
        fail_data  <= dout_sel;
      end
`ifdef IOB_RAM_TDP_BIST_ERRCNT_EN
      if (mm && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
`endif
      case (state)
        IDLE: if (start) begin
          seed       <= seq_ini;
          ok         <= 1'b1;
          busy       <= 1'b1;
          done       <= 1'b0;
          pass       <= 1'b0;
          fail_phase <= '0;
          fail_addr  <= '0;
          fail_data  <= '0;
          state      <= WR_A;
          i          <= '0;
          enA        <= 1'b1;
          weA        <= 1'b1;
          addrA      <= '0;
          dinA       <= seq_ini;
`ifdef IOB_RAM_TDP_BIST_ERRCNT_EN
          err_cnt    <= '0;
`endif
        end
        WR_A: if (i == LAST) begin
          state <= RD_B;
          i     <= '0;
          enA   <= 1'b0;
          weA   <= 1'b0;
          enB   <= 1'b1;
          weB   <= 1'b0;
          addrB <= '0;
        end else begin
          i     <= nxt_i;
          addrA <= nxt_i[ADDR_W-1:0];
          dinA  <= pat_a;
        end
        RD_B: if (abort) begin
          state <= DONE;
          enA   <= 1'b0;
          weA   <= 1'b0;
          enB   <= 1'b0;
          weB   <= 1'b0;
        end else if (i == LAST) begin
          i   <= DRAIN;
          enB <= 1'b0;
        end else if (i == DRAIN) begin
          state <= WR_B;
          i     <= '0;
          enB   <= 1'b1;
          weB   <= 1'b1;
          addrB <= '0;
          dinB  <= ~seed;
        end else begin
          i     <= nxt_i;
          addrB <= nxt_i[ADDR_W-1:0];
        end
        WR_B: if (i == LAST) begin
          state <= RD_A;
          i     <= '0;
          enB   <= 1'b0;
          weB   <= 1'b0;
          enA   <= 1'b1;
          weA   <= 1'b0;
          addrA <= '0;
        end else begin
          i     <= nxt_i;
          addrB <= nxt_i[ADDR_W-1:0];
          dinB  <= pat_b;
        end
        RD_A: if (abort || (i == DRAIN)) begin
          state <= DONE;
          enA   <= 1'b0;
          weA   <= 1'b0;
          enB   <= 1'b0;
          weB   <= 1'b0;
        end else if (i == LAST) begin
          i   <= DRAIN;
          enA <= 1'b0;
        end else begin
          i     <= nxt_i;
          addrA <= nxt_i[ADDR_W-1:0];
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= ok;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_ram_tdp_bist.sv
// Scoreboard bench for iob_ram_tdp_bist with a behavioural registered-output dual-port RAM.
module tb_iob_ram_tdp_bist;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int N      = 16;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [DATA_W-1:0] seq_ini = '0;
  logic              busy, done, pass, enA, weA, enB, weB;
  logic [1:0]        fail_phase;
  logic [ADDR_W-1:0] fail_addr, addrA, addrB;
  logic [DATA_W-1:0] fail_data, dinA, dinB, doutA, doutB;
`ifdef IOB_RAM_TDP_BIST_ERRCNT_EN
  logic [ADDR_W+1:0] err_cnt;
`endif

  always #5 clk = ~clk;

  iob_ram_tdp_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seq_ini(seq_ini),
    .busy(busy), .done(done), .pass(pass),
    .fail_phase(fail_phase), .fail_addr(fail_addr), .fail_data(fail_data),
    .enA(enA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(doutA),
    .enB(enB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutB)
`ifdef IOB_RAM_TDP_BIST_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  // RAM model with fault injection on the read data paths
  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] ra, rb;
  logic [ADDR_W-1:0] ra_addr, rb_addr;
  logic              flip_en = 1'b0;
  logic [ADDR_W-1:0] flip_addr = '0;
  logic [N-1:0]      zero_mask = '0;

  always @(posedge clk) begin
    if (enA) begin
      if (weA) mem[addrA] <= dinA;
      else begin ra <= mem[addrA]; ra_addr <= addrA; end
    end
    if (enB) begin
      if (weB) mem[addrB] <= dinB;
      else begin rb <= mem[addrB]; rb_addr <= addrB; end
    end
  end
  assign doutA = zero_mask[ra_addr] ? '0 : ra;
  assign doutB = rb ^ {{(DATA_W-1){1'b0}}, (flip_en && rb_addr == flip_addr)};

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
  typedef struct {
    int lat; logic ok; logic [1:0] ph; logic [ADDR_W-1:0] fa; logic [DATA_W-1:0] fd;
    int errs; int wa_left; int wb_left;
  } res_t;

  wr_t  qa[$], qb[$];
  res_t qr[$];
  int   n_chk = 0, n_err = 0, cyc = 0, t0 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every observed RAM write must match the next expected one.
  always @(negedge clk) begin
    wr_t w;
    if (rst_n) begin
      if (enA && enB) check("port_overlap", 1, 0);
      if (enA && weA) begin
        if (qa.size() == 0) check("wrA_extra", 0, 1);
        else begin w = qa.pop_front(); check("wrA", {addrA, dinA}, {w.a, w.d}); end
      end
      if (enB && weB) begin
        if (qb.size() == 0) check("wrB_extra", 0, 1);
        else begin w = qb.pop_front(); check("wrB", {addrB, dinB}, {w.a, w.d}); end
      end
    end
  end

  function automatic res_t mk(int lat, logic ok, logic [1:0] ph, logic [ADDR_W-1:0] fa,
                              logic [DATA_W-1:0] fd, int errs, int wa, int wb);
    res_t r;
    r.lat = lat; r.ok = ok; r.ph = ph; r.fa = fa; r.fd = fd;
    r.errs = errs; r.wa_left = wa; r.wb_left = wb;
    return r;
  endfunction

  task automatic do_start(input logic [DATA_W-1:0] s, input bit push, input res_t r);
    wr_t w;
    @(negedge clk);
    qa.delete(); qb.delete();
    for (int k = 0; k < N; k++) begin
      w.a = ADDR_W'(k); w.d = s + DATA_W'(k); qa.push_back(w);
      w.d = ~(s + DATA_W'(k)); qb.push_back(w);
    end
    if (push) qr.push_back(r);
    seq_ini = s; start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; start = 1'b0;
    check("busy_after_start", {busy, done}, 2'b10);
  endtask

  task automatic wait_done(input int budget);
    int   k;
    res_t r;
    k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    r = qr.pop_front();
    if (!done) check("done_timeout", 0, 1);
    else begin
      check("latency", cyc - t0, r.lat);
      check("pass", pass, r.ok);
      check("busy_at_done", busy, 0);
      check("fail_diag", {fail_phase, fail_addr, fail_data}, {r.ph, r.fa, r.fd});
      check("wrA_left", qa.size(), r.wa_left);
      check("wrB_left", qb.size(), r.wb_left);
`ifdef IOB_RAM_TDP_BIST_ERRCNT_EN
      check("err_cnt", err_cnt, r.errs);
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    res_t r;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {busy, done, pass, enA, weA, enB, weB}, 0);
    check("rst_fail", {fail_phase, fail_addr, fail_data}, 0);
    check("rst_bus", {addrA, addrB, dinA, dinB}, 0);
    rst_n = 1'b1;

    // basic pass, then hold of done in IDLE
    do_start(8'h20, 1, mk(67, 1, 0, 0, 0, 0, 0, 0));
    wait_done(200);
    @(negedge clk);
    check("done_hold", {done, pass, busy}, 3'b110);

    // pattern wraps past 0xFF
    do_start(8'hF8, 1, mk(67, 1, 0, 0, 0, 0, 0, 0));
    wait_done(200);

    // single bit fault on port B read of address 5: issue cycle 22, compare 23, DONE 24
    flip_en = 1'b1; flip_addr = 4'd5;
`ifdef IOB_RAM_TDP_BIST_ERRCNT_EN
    r = mk(67, 0, 2'd1, 4'd5, 8'h44, 1, 0, 0);
`else
    r = mk(24, 0, 2'd1, 4'd5, 8'h44, 0, 0, 16);
`endif
    do_start(8'h40, 1, r);
    wait_done(200);
    flip_en = 1'b0;

    // port A reads forced to zero at addresses 2 and 9
    zero_mask = 16'h0204;
`ifdef IOB_RAM_TDP_BIST_ERRCNT_EN
    r = mk(67, 0, 2'd3, 4'd2, 8'h00, 2, 0, 0);
`else
    r = mk(54, 0, 2'd3, 4'd2, 8'h00, 0, 0, 0);
`endif
    do_start(8'h20, 1, r);
    wait_done(200);
    zero_mask = '0;

    // reset while RD_B is at i=7 (cycle 24 after acceptance)
    do_start(8'h20, 0, r);
    repeat (23) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    check("abort_ctl", {busy, done, pass, enA, weA, enB, weB}, 0);
    do_start(8'h20, 1, mk(67, 1, 0, 0, 0, 0, 0, 0));
    wait_done(200);

    // second start while busy must be ignored
    do_start(8'h11, 1, mk(67, 1, 0, 0, 0, 0, 0, 0));
    repeat (9) @(posedge clk);
    @(negedge clk); seq_ini = 8'h55; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; seq_ini = 8'hAA;
    wait_done(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
